reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-read-port register file with hardwired zero register, byte-enable writes, an optional write-to-read bypass and a hardware clear sequencer. Successor to the fixed 32x32 two-read-port register array in the core's decode stage. Serves the RV32 integer datapath (defaults) and wider or narrower configurations without RTL edits. Storage is a plain array with no per-entry reset; a clear FSM zeroes it after reset or on request and gates reads until done.

## Interface
- DATA_W, 32, register width in bits; multiple of 8
- ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
- NUM_RD, 2, number of independent read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes
- clk_Regs  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- Reg_Write  in  1  write enable
- W_Addr  in  ADDR_W  write address
- W_Data  in  DATA_W  write data
- W_BE  in  DATA_W/8  byte write enables; bit k covers W_Data[8k+7:8k]
- R_Addr  in  NUM_RD*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W]
- R_Data  out  NUM_RD*DATA_W  packed read data; port p at [p*DATA_W +: DATA_W]
- Clr_Req  in  1  single-cycle request to zero the whole file
- Ready  out  1  file cleared and accepting writes

## Operation
- FSM states: CLEAR, READY. Clear pointer clr_ptr, ADDR_W bits.
- rst_n low: state=CLEAR, clr_ptr=0, Ready=0. Array contents not reset.
- CLEAR: each edge writes 0 to entry clr_ptr, clr_ptr+1. On the edge where clr_ptr==NUM_REGS-1: state->READY, clr_ptr wraps to 0.
- CLEAR: Reg_Write ignored (dropped, no queuing); Clr_Req ignored; every R_Data port drives 0.
- READY: Reg_Write=1 -> for each k with W_BE[k]=1, entry W_Addr byte k <= W_Data byte k; other bytes keep their value.
- READY: Clr_Req=1 -> state->CLEAR next edge; a write in the same cycle is dropped (clear has priority).
- ZERO_REG=1: writes to address 0 are discarded; any port reading address 0 returns 0 in all states.
- Reads combinational from R_Addr; all ports independent; identical addresses on several ports legal.
- Reads in READY with no bypass hit return the array value.

## Timing
- Reset values: Ready=0, R_Data=all 0 (masked by CLEAR).
- First clear write on first rising edge after rst_n deasserts; Ready=1 after exactly NUM_REGS rising edges (32 at defaults).
- Clr_Req in READY: Ready=0 from the next edge; Ready=1 again NUM_REGS edges after that.
- Write latency: visible in array after the write edge (1 cycle); with bypass, same cycle.
- rst_n asserted mid-clear: restart from clr_ptr=0, full NUM_REGS cycles again.
- rst_n asserted mid-write: write edge-qualified, so no partial write at reset assertion.
- Clr_Req held high: only the cycle seen in READY matters; re-arms only after READY reached and Clr_Req sampled again.

## Configuration
- REG_FILE_MP_BYPASS_EN defined: in READY, if Reg_Write=1, R_Addr of a port == W_Addr, and address is not 0 (when ZERO_REG=1), that port returns merged data combinationally: W_Data bytes where W_BE=1, stored bytes elsewhere.
- Not defined: ports return the stored (pre-write) value in the write cycle; new value visible from the next cycle. No bypass mux logic present.

## Test plan
- Reset release, default params -> Ready=0 for 32 edges, rises on 32nd; all entries read 0; Reg_Write during clear leaves entry 5 = 0 afterward.
- READY, write entry 3 = 0xDEADBEEF, W_BE=4'b1111, then W_BE=4'b0010 with 0x00001200 -> entry 3 reads 0xDEAD12EF on both ports.
- Write 0xFFFFFFFF to address 0 with ZERO_REG=1 -> all ports reading 0 return 0x00000000 in write cycle and after.
- Bypass: write 7 = 0xA5A5A5A5 while port 1 reads 7 -> with REG_FILE_MP_BYPASS_EN, R_Data port 1 = 0xA5A5A5A5 same cycle; without, old value that cycle, new value next cycle.
- Clr_Req with simultaneous write to 9 = 0x1 -> write dropped, Ready low 32 cycles, entry 9 reads 0; rst_n pulse at clear cycle 10 -> Ready rises 32 edges after release.
- NUM_RD=4, DATA_W=64, ADDR_W=4 -> Ready after 16 edges; four ports reading 1,2,2,15 return their written 64-bit values independently.

Source files
------------

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: write port, packed read ports, clear request and Ready.
// master = datapath side, slave = register file.
interface reg_file_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic                       Reg_Write;
   logic [ADDR_W-1:0]          W_Addr;
   logic [DATA_W-1:0]          W_Data;
   logic [DATA_W/8-1:0]        W_BE;
   logic [NUM_RD*ADDR_W-1:0]   R_Addr;
   logic [NUM_RD*DATA_W-1:0]   R_Data;
   logic                       Clr_Req;
   logic                       Ready;

   modport master (
      output Reg_Write, W_Addr, W_Data, W_BE, R_Addr, Clr_Req,
      input  R_Data, Ready
   );

   modport slave (
      input  Reg_Write, W_Addr, W_Data, W_BE, R_Addr, Clr_Req,
      output R_Data, Ready
   );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with zero register, byte-enable writes and a clear sequencer.
// Define REG_FILE_MP_BYPASS_EN to forward same-cycle write data to matching read ports.

module reg_file_mp_rd #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   i_stored,
`ifdef REG_FILE_MP_BYPASS_EN
   input  logic [DATA_W-1:0]   i_wdata,
   input  logic [DATA_W/8-1:0] i_be,
   input  logic                i_hit,
`endif
   input  logic                i_mask,
   output logic [DATA_W-1:0]   o_data
);
   logic [DATA_W-1:0] w_word;

`ifdef REG_FILE_MP_BYPASS_EN
   // Merge only the enabled bytes so a partial write forwards exactly what will be stored.
   always_comb begin
      w_word = i_stored;
      if (i_hit) begin
         for (int k = 0; k < DATA_W/8; k++) begin
            if (i_be[k]) w_word[8*k +: 8] = i_wdata[8*k +: 8];
         end
      end
   end
`else
   assign w_word = i_stored;
`endif

   assign o_data = i_mask ? '0 : w_word;
endmodule

module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic          clk_Regs,
   input  logic          rst_n,
   reg_file_mp_if.slave  bus
);
   localparam int NUM_REGS = 1 << ADDR_W;
   localparam int NUM_BE   = DATA_W / 8;

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_clr_ptr, w_clr_ptr_nxt;
   logic              w_ready;
   logic              w_wr_en;
   logic              w_wr_zero;
   logic [DATA_W-1:0] r_mem [NUM_REGS];

   assign w_wr_zero = (ZERO_REG != 0) && (bus.W_Addr == '0);

   always_ff @(posedge clk_Regs or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_CLEAR;
         r_clr_ptr <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_clr_ptr <= w_clr_ptr_nxt;
      end
   end

   // Clear wins over a same-cycle write; writes and clear requests are dropped while clearing.
   always_comb begin
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      w_ready       = 1'b0;
      w_wr_en       = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
            if (&r_clr_ptr) w_state_nxt = ST_READY;
         end
         ST_READY: begin
            w_ready = 1'b1;
            if (bus.Clr_Req) w_state_nxt = ST_CLEAR;
            else             w_wr_en     = bus.Reg_Write && !w_wr_zero;
         end
         default: w_state_nxt = ST_CLEAR;
      endcase
   end

   assign bus.Ready = w_ready;

   // Storage has no reset; the sequencer zeroes it one entry per cycle.
   always_ff @(posedge clk_Regs) begin
      if (r_state == ST_CLEAR) begin
         r_mem[r_clr_ptr] <= '0;
      end else if (w_wr_en) begin
         for (int k = 0; k < NUM_BE; k++) begin
            if (bus.W_BE[k]) r_mem[bus.W_Addr][8*k +: 8] <= bus.W_Data[8*k +: 8];
         end
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic              w_zero;

      assign w_addr = bus.R_Addr[p*ADDR_W +: ADDR_W];
      assign w_zero = (ZERO_REG != 0) && (w_addr == '0);

`ifdef REG_FILE_MP_BYPASS_EN
      logic w_hit;
      assign w_hit = w_wr_en && (w_addr == bus.W_Addr);
`endif

      reg_file_mp_rd #(.DATA_W(DATA_W)) u_rd (
         .i_stored (r_mem[w_addr]),
`ifdef REG_FILE_MP_BYPASS_EN
         .i_wdata  (bus.W_Data),
         .i_be     (bus.W_BE),
         .i_hit    (w_hit),
`endif
         .i_mask   (!w_ready || w_zero),
         .o_data   (bus.R_Data[p*DATA_W +: DATA_W])
      );
   end
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: default 32x32/2-port instance plus a 16x64/4-port instance.
module tb_reg_file_mp;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

`ifdef REG_FILE_MP_BYPASS_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   reg_file_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();
   reg_file_mp_if #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4)) wbus ();

   reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) u_dut (
      .clk_Regs (clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   reg_file_mp #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) u_wide (
      .clk_Regs (clk),
      .rst_n    (rst_n),
      .bus      (wbus)
   );

   typedef struct {
      string       name;
      int          dut;
      int          port;
      logic [63:0] exp;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic void sb_push(input string n, input int d, input int p, input logic [63:0] x);
      exp_t t;
      t.name = n; t.dut = d; t.port = p; t.exp = x;
      sb_q.push_back(t);
   endfunction

   function automatic logic [63:0] rd_port(input int d, input int p);
      if (d == 0) return {32'h0, bus.R_Data[p*32 +: 32]};
      return wbus.R_Data[p*64 +: 64];
   endfunction

   task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
      bus.Reg_Write = 1'b1; bus.W_Addr = a; bus.W_Data = d; bus.W_BE = be;
   endtask

   task automatic idle();
      bus.Reg_Write = 1'b0; bus.Clr_Req = 1'b0;
   endtask

   task automatic wwr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] be);
      wbus.Reg_Write = 1'b1; wbus.W_Addr = a; wbus.W_Data = d; wbus.W_BE = be;
   endtask

   task automatic test_reset();
      int   n0 = 0;
      int   n1 = 0;
      exp_t e;
      rst_n = 1'b0;
      bus.R_Addr = {5'd3, 5'd0};
      #1;
      checks++;
      if (bus.Ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", bus.Ready); end
      checks++;
      if (bus.R_Data !== '0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", bus.R_Data); end
      @(negedge clk);
      rst_n = 1'b1;
      wr(5'd5, 32'hFFFF_FFFF, 4'hF);
      bus.Clr_Req = 1'b1;
      bus.R_Addr = {5'd5, 5'd1};
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (i == 4) bus.Clr_Req = 1'b0;
         if (i == 3) begin
            checks++;
            if (bus.R_Data !== '0) begin failures++; $display("FAIL clear_rdata_masked: got %h expected 0", bus.R_Data); end
         end
         if (n0 == 0 && bus.Ready === 1'b1) begin n0 = i; bus.Reg_Write = 1'b0; end
         if (n1 == 0 && wbus.Ready === 1'b1) n1 = i;
         if (n0 != 0 && n1 != 0) break;
      end
      idle();
      checks++;
      if (n0 != 32) begin failures++; $display("FAIL reset_ready_edges: got %0d expected 32", n0); end
      checks++;
      if (n1 != 16) begin failures++; $display("FAIL wide_ready_edges: got %0d expected 16", n1); end
      for (int a = 0; a < 32; a++) begin
         @(negedge clk);
         bus.R_Addr = {5'(a), 5'(a)};
         #1;
         sb_push("cleared_p0", 0, 0, 64'h0);
         sb_push("cleared_p1", 0, 1, 64'h0);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); checks++;
            if (rd_port(e.dut, e.port) !== e.exp) begin
               failures++; $display("FAIL %s addr %0d: got %h expected %h", e.name, a, rd_port(e.dut, e.port), e.exp);
            end
         end
      end
   endtask

   task automatic test_byte_en();
      exp_t e;
      @(negedge clk); wr(5'd3, 32'hDEAD_BEEF, 4'b1111);
      @(negedge clk); wr(5'd3, 32'h0000_1200, 4'b0010);
      @(negedge clk); idle();
      bus.R_Addr = {5'd3, 5'd3};
      #1;
      sb_push("be_p0", 0, 0, 64'hDEAD_12EF);
      sb_push("be_p1", 0, 1, 64'hDEAD_12EF);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front(); checks++;
         if (rd_port(e.dut, e.port) !== e.exp) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, rd_port(e.dut, e.port), e.exp);
         end
      end
   endtask

   task automatic test_zero_reg();
      exp_t e;
      @(negedge clk); wr(5'd0, 32'hFFFF_FFFF, 4'hF);
      bus.R_Addr = {5'd0, 5'd0};
      #1;
      sb_push("zero_wcycle_p0", 0, 0, 64'h0);
      sb_push("zero_wcycle_p1", 0, 1, 64'h0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front(); checks++;
         if (rd_port(e.dut, e.port) !== e.exp) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, rd_port(e.dut, e.port), e.exp);
         end
      end
      @(negedge clk); idle();
      #1;
      sb_push("zero_after_p0", 0, 0, 64'h0);
      sb_push("zero_after_p1", 0, 1, 64'h0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front(); checks++;
         if (rd_port(e.dut, e.port) !== e.exp) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, rd_port(e.dut, e.port), e.exp);
         end
      end
   endtask

   task automatic test_bypass();
      exp_t e;
      @(negedge clk); wr(5'd7, 32'h1111_1111, 4'hF);
      @(negedge clk); wr(5'd7, 32'hA5A5_A5A5, 4'hF);
      bus.R_Addr = {5'd7, 5'd3};
      #1;
      sb_push("bp_other_port", 0, 0, 64'hDEAD_12EF);
      sb_push("bp_full_word", 0, 1, BP ? 64'hA5A5_A5A5 : 64'h1111_1111);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front(); checks++;
         if (rd_port(e.dut, e.port) !== e.exp) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, rd_port(e.dut, e.port), e.exp);
         end
      end
      @(negedge clk); wr(5'd7, 32'h0000_00FF, 4'b0001);
      #1;
      sb_push("bp_prev_visible", 0, 1, BP ? 64'hA5A5_A5FF : 64'hA5A5_A5A5);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front(); checks++;
         if (rd_port(e.dut, e.port) !== e.exp) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, rd_port(e.dut, e.port), e.exp);
         end
      end
      @(negedge clk); idle();
      #1;
      sb_push("bp_after", 0, 1, 64'hA5A5_A5FF);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front(); checks++;
         if (rd_port(e.dut, e.port) !== e.exp) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, rd_port(e.dut, e.port), e.exp);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] m [8];
      logic [31:0] d;
      logic [3:0]  be;
      int          a;
      exp_t        e;
      for (int i = 0; i < 8; i++) m[i] = '0;
      for (int i = 0; i < 10; i++) begin
         a  = i % 6;
         d  = $urandom;
         be = 4'($urandom_range(1, 15));
         @(negedge clk); wr(5'(10 + a), d, be);
         for (int k = 0; k < 4; k++) if (be[k]) m[a][8*k +: 8] = d[8*k +: 8];
      end
      @(negedge clk); idle();
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         bus.R_Addr = {5'(17 - j), 5'(10 + j)};
         #1;
         sb_push("b2b_p0", 0, 0, {32'h0, m[j]});
         sb_push("b2b_p1", 0, 1, {32'h0, m[7 - j]});
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front(); checks++;
            if (rd_port(e.dut, e.port) !== e.exp) begin
               failures++; $display("FAIL %s idx %0d: got %h expected %h", e.name, j, rd_port(e.dut, e.port), e.exp);
            end
         end
      end
   endtask

   task automatic test_wide();
      exp_t e;
      @(negedge clk); wwr(4'd1,  64'h0123_4567_89AB_CDEF, 8'hFF);
      @(negedge clk); wwr(4'd2,  64'hFEDC_BA98_7654_3210, 8'hFF);
      @(negedge clk); wwr(4'd15, 64'hDEAD_BEEF_CAFE_F00D, 8'hFF);
      @(negedge clk); wwr(4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
      @(negedge clk); wwr(4'd2,  64'h1111_1111_2222_2222, 8'hF0);
      @(negedge clk); wbus.Reg_Write = 1'b0;
      wbus.R_Addr = {4'd15, 4'd2, 4'd2, 4'd1};
      #1;
      sb_push("wide_p0_a1",  1, 0, 64'h0123_4567_89AB_CDEF);
      sb_push("wide_p1_a2",  1, 1, 64'h1111_1111_7654_3210);
      sb_push("wide_p2_a2",  1, 2, 64'h1111_1111_7654_3210);
      sb_push("wide_p3_a15", 1, 3, 64'hDEAD_BEEF_CAFE_F00D);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front(); checks++;
         if (rd_port(e.dut, e.port) !== e.exp) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, rd_port(e.dut, e.port), e.exp);
         end
      end
      @(negedge clk);
      wbus.R_Addr = {4'd0, 4'd15, 4'd1, 4'd0};
      #1;
      sb_push("wide_p0_a0",  1, 0, 64'h0);
      sb_push("wide_p1_a1",  1, 1, 64'h0123_4567_89AB_CDEF);
      sb_push("wide_p2_a15", 1, 2, 64'hDEAD_BEEF_CAFE_F00D);
      sb_push("wide_p3_a0",  1, 3, 64'h0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front(); checks++;
         if (rd_port(e.dut, e.port) !== e.exp) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, rd_port(e.dut, e.port), e.exp);
         end
      end
   endtask

   task automatic test_clear();
      int   n = 0;
      exp_t e;
      @(negedge clk);
      bus.Clr_Req = 1'b1;
      wr(5'd9, 32'h0000_0001, 4'hF);
      bus.R_Addr = {5'd9, 5'd3};
      @(posedge clk); #1;
      idle();
      checks++;
      if (bus.Ready !== 1'b0) begin failures++; $display("FAIL clr_ready_low: got %b expected 0", bus.Ready); end
      sb_push("clr_masked_p0", 0, 0, 64'h0);
      sb_push("clr_masked_p1", 0, 1, 64'h0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front(); checks++;
         if (rd_port(e.dut, e.port) !== e.exp) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, rd_port(e.dut, e.port), e.exp);
         end
      end
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (bus.Ready === 1'b1) begin n = i; break; end
      end
      checks++;
      if (n != 32) begin failures++; $display("FAIL clr_ready_edges: got %0d expected 32", n); end
      @(negedge clk);
      #1;
      sb_push("clr_entry3", 0, 0, 64'h0);
      sb_push("clr_entry9", 0, 1, 64'h0);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front(); checks++;
         if (rd_port(e.dut, e.port) !== e.exp) begin
            failures++; $display("FAIL %s: got %h expected %h", e.name, rd_port(e.dut, e.port), e.exp);
         end
      end
   endtask

   task automatic test_rst_mid_clear();
      int n0 = 0;
      int n1 = 0;
      @(negedge clk); bus.Clr_Req = 1'b1;
      @(negedge clk); bus.Clr_Req = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      checks++;
      if (bus.Ready !== 1'b0 || wbus.Ready !== 1'b0) begin
         failures++; $display("FAIL rst_async_ready: got %b/%b expected 0/0", bus.Ready, wbus.Ready);
      end
      @(negedge clk); rst_n = 1'b1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk); #1;
         if (n0 == 0 && bus.Ready === 1'b1) n0 = i;
         if (n1 == 0 && wbus.Ready === 1'b1) n1 = i;
         if (n0 != 0 && n1 != 0) break;
      end
      checks++;
      if (n0 != 32) begin failures++; $display("FAIL rst_mid_clear_edges: got %0d expected 32", n0); end
      checks++;
      if (n1 != 16) begin failures++; $display("FAIL rst_wide_edges: got %0d expected 16", n1); end
   endtask

   initial begin
      bus.Reg_Write  = 1'b0; bus.W_Addr  = '0; bus.W_Data  = '0; bus.W_BE  = '0;
      bus.R_Addr     = '0;   bus.Clr_Req = 1'b0;
      wbus.Reg_Write = 1'b0; wbus.W_Addr = '0; wbus.W_Data = '0; wbus.W_BE = '0;
      wbus.R_Addr    = '0;   wbus.Clr_Req = 1'b0;
      test_reset();
      test_byte_en();
      test_zero_reg();
      test_bypass();
      test_back_to_back();
      test_wide();
      test_clear();
      test_rst_mid_clear();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
